ide_host_pio: RTL and testbench
===============================

Name: ide_host_pio

Overview:
- PIO-mode ATA host initiator; the host end of the IDE bus that the device-side register interface serves.
- Turns single register read/write requests from a local controller into ATA bus cycles with programmable setup, pulse, hold and recovery times.
- Honours IORDY wait states and returns read data.
- Synchronises INTRQ back to the controller as a level interrupt.
- Used for bench/host-emulation builds driving the drive-side FPGA.

Parameters:
- T_SETUP, 3: cycles CS/DA valid before strobe asserts (min 1).
- T_PULSE, 12: minimum cycles DIOR_/DIOW_ held low (min 2).
- T_HOLD, 2: cycles CS/DA/write data held after strobe release (min 1).
- T_RECOV, 8: idle cycles after cycle end before next request is accepted (min 1).
- IORDY_TIMEOUT, 1024: max extra pulse cycles waiting for IORDY before abort.

Ports:
- clk  in  1  system clock
- reset_  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1=write, 0=read (sampled with req)
- addr  in  4  [3]=0 command block (cs1fx_), [3]=1 control block (cs3fx_); [2:0]=DA
- wdata  in  16  write data (sampled with req)
- busy  out  1  engine not idle
- ack  out  1  one-cycle completion pulse
- err  out  1  valid with ack; 1 = IORDY timeout
- rdata  out  16  read data, valid from ack until next ack
- irq  out  1  synchronised INTRQ level
- da  out  3  ATA address
- cs1fx_  out  1  command block select, active low
- cs3fx_  out  1  control block select, active low
- dior_  out  1  read strobe, active low
- diow_  out  1  write strobe, active low
- dd_out  out  16  data to bus
- dd_oe  out  1  data bus drive enable
- dd_in  in  16  data from bus
- iordy  in  1  device ready; asynchronous
- intrq  in  1  device interrupt; asynchronous

Behaviour:
- Reset values: busy=0, ack=0, err=0, rdata=0, irq=0, da=0, cs1fx_=1, cs3fx_=1, dior_=1, diow_=1, dd_oe=0, dd_out=0. State=IDLE. Synchroniser flops: iordy=1, intrq=0.
- iordy and intrq each pass through a 2-flop synchroniser; irq is the synchroniser output.
- States: IDLE, SETUP, PULSE, HOLD, RECOV. Entering a state with parameter N loads a down-counter; the state lasts exactly N cycles unless extended.
- IDLE: when req=1, latch we/addr/wdata and go to SETUP. busy=1 from the next cycle.
- SETUP:
  - da=addr[2:0]; exactly one of cs1fx_/cs3fx_ low per addr[3].
  - For writes, dd_oe=1 and dd_out=wdata from the first SETUP cycle.
- PULSE:
  - dior_ (read) or diow_ (write) low.
  - After T_PULSE cycles, stay while synced iordy=0, counting extra cycles.
  - Leave on the first cycle with count expired and iordy=1: reads latch dd_in into rdata on that last PULSE cycle, then go to HOLD.
  - If extra cycles reach IORDY_TIMEOUT: set rdata=16'hFFFF for reads, err pending=1, go to HOLD.
- HOLD: strobe high; CS/DA and dd_oe/dd_out (write) unchanged.
- HOLD→RECOV transition:
  - ack=1 for one cycle on the first RECOV cycle, with err.
  - cs1fx_=cs3fx_=1, dd_oe=0; da keeps its last value.
- RECOV: after T_RECOV cycles, go to IDLE; busy=0 in IDLE.
- Minimum latency: req cycle → ack = 1+T_SETUP+T_PULSE+T_HOLD cycles (defaults: 18). The next req is accepted no earlier than T_RECOV cycles after ack.
- req while busy=1 is ignored; it is not queued.
- Strobes never glitch: at most one of dior_/diow_ low at any time, and only in PULSE.
- Reset asserted mid-cycle: all outputs return to reset values immediately (asynchronous). No ack is produced for the aborted request.

Test Plan:
- Write addr=4'h7, wdata=16'h00A0, iordy=1 → cs1fx_=0, da=7, dd_oe=1 with dd_out=00A0. diow_ low exactly 12 cycles; cs1fx_ low 17 cycles. ack 18 cycles after req, err=0. busy drops 8 cycles after ack.
- Read addr=4'hE, dd_in=16'h0050 → cs3fx_=0, da=6, dior_ low 12 cycles, dd_oe=0 throughout. ack with rdata=0050, err=0.
- Read with iordy held low from SETUP until 20 cycles into PULSE → dior_ low 22 cycles (20 + 2 sync). rdata is dd_in sampled on the last low cycle; err=0.
- iordy stuck low, IORDY_TIMEOUT=16 → dior_ low 12+16 cycles, then ack with err=1, rdata=FFFF. The next request completes normally once iordy=1.
- req pulsed again during RECOV and held high → second cycle starts only after busy=0. Exactly two acks, never overlapping strobes.
- intrq toggled → irq follows after 2 clocks. reset_ low during PULSE → dior_/diow_/cs*_ high and busy=0 asynchronously, no ack.

Source files
------------

// File: rtl/ide_host_pio.sv
// PIO-mode ATA host initiator: turns single register read/write requests into
// timed ATA bus cycles, honours IORDY wait states and synchronises INTRQ.
module ide_host_pio #(
    parameter int unsigned T_SETUP       = 3,
    parameter int unsigned T_PULSE       = 12,
    parameter int unsigned T_HOLD        = 2,
    parameter int unsigned T_RECOV       = 8,
    parameter int unsigned IORDY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        irq,
    output logic [2:0]  da,
    output logic        cs1fx_,
    output logic        cs3fx_,
    output logic        dior_,
    output logic        diow_,
    output logic [15:0] dd_out,
    output logic        dd_oe,
    input  logic [15:0] dd_in,
    input  logic        iordy,
    input  logic        intrq,
    output logic [2:0]  dbg_state_o
);
    // Handshake: req/we/addr/wdata are taken only on a cycle where busy=0; every
    // accepted request yields exactly one ack pulse, with err valid alongside it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        RECOV = 3'd4
    } state_t;

    localparam int CW = 16;
    localparam int XW = $clog2(IORDY_TIMEOUT + 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] RECOV_LD = CW'(T_RECOV - 1);
    localparam logic [XW-1:0] XMAX     = XW'(IORDY_TIMEOUT);

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [XW-1:0]  extra_q;
    logic           we_q;
    logic           err_pend_q;
    logic           busy_q;
    logic           ack_q;
    logic           err_q;
    logic [15:0]    rdata_q;
    logic [2:0]     da_q;
    logic           cs1_q;
    logic           cs3_q;
    logic           dior_q;
    logic           diow_q;
    logic [15:0]    dd_out_q;
    logic           dd_oe_q;
    logic           iordy_s1_q;
    logic           iordy_s2_q;
    logic           intrq_s1_q;
    logic           intrq_s2_q;

    // Both device signals are asynchronous to clk; iordy idles high (ready).
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            iordy_s1_q <= 1'b1;
            iordy_s2_q <= 1'b1;
            intrq_s1_q <= 1'b0;
            intrq_s2_q <= 1'b0;
        end else begin
            iordy_s1_q <= iordy;
            iordy_s2_q <= iordy_s1_q;
            intrq_s1_q <= intrq;
            intrq_s2_q <= intrq_s1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            extra_q    <= '0;
            we_q       <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            da_q       <= '0;
            cs1_q      <= 1'b1;
            cs3_q      <= 1'b1;
            dior_q     <= 1'b1;
            diow_q     <= 1'b1;
            dd_out_q   <= '0;
            dd_oe_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q    <= SETUP;
                        cnt_q      <= SETUP_LD;
                        extra_q    <= '0;
                        err_pend_q <= 1'b0;
                        we_q       <= we;
                        busy_q     <= 1'b1;
                        da_q       <= addr[2:0];
                        cs1_q      <= addr[3];
                        cs3_q      <= ~addr[3];
                        if (we) begin
                            dd_oe_q  <= 1'b1;
                            dd_out_q <= wdata;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= PULSE;
                        cnt_q   <= PULSE_LD;
                        if (we_q) begin
                            diow_q <= 1'b0;
                        end else begin
                            dior_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    // Minimum width first, then stretch while the device holds IORDY low.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (iordy_s2_q) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        dior_q  <= 1'b1;
                        diow_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= dd_in;
                        end
                    end else if (extra_q == XMAX) begin
                        state_q    <= HOLD;
                        cnt_q      <= HOLD_LD;
                        dior_q     <= 1'b1;
                        diow_q     <= 1'b1;
                        err_pend_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= 16'hFFFF;
                        end
                    end else begin
                        extra_q <= extra_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= RECOV;
                        cnt_q   <= RECOV_LD;
                        ack_q   <= 1'b1;
                        err_q   <= err_pend_q;
                        cs1_q   <= 1'b1;
                        cs3_q   <= 1'b1;
                        dd_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RECOV: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign irq         = intrq_s2_q;
    assign da          = da_q;
    assign cs1fx_      = cs1_q;
    assign cs3fx_      = cs3_q;
    assign dior_       = dior_q;
    assign diow_       = diow_q;
    assign dd_out      = dd_out_q;
    assign dd_oe       = dd_oe_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ide_host_pio.sv
// Bench for ide_host_pio: transaction-level reference model with per-cycle
// output comparison, directed timing scenarios and a randomized phase.
module tb_ide_host_pio;
    localparam int T_SETUP = 3;
    localparam int T_PULSE = 12;
    localparam int T_HOLD  = 2;
    localparam int T_RECOV = 8;
    localparam int TMO     = 16;

    logic        clk = 1'b0;
    logic        reset_ = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] dd_in = '0;
    logic        iordy = 1'b1;
    logic        intrq = 1'b0;
    logic        busy, ack, err, irq, cs1fx_, cs3fx_, dior_, diow_, dd_oe;
    logic [15:0] rdata, dd_out;
    logic [2:0]  da, dbg_state;

    int total = 0;
    int bad = 0;
    int rand_acks = 0;
    logic rand_phase = 1'b0;

    always #5 clk = ~clk;

    ide_host_pio #(
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_RECOV(T_RECOV), .IORDY_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_(reset_), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .err(err), .rdata(rdata), .irq(irq), .da(da),
        .cs1fx_(cs1fx_), .cs3fx_(cs3fx_), .dior_(dior_), .diow_(diow_),
        .dd_out(dd_out), .dd_oe(dd_oe), .dd_in(dd_in), .iordy(iordy), .intrq(intrq),
        .dbg_state_o(dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is described by its cycle index t since
    // acceptance and its pulse length, fixed once the pulse is seen to end.
    logic        m_active = 1'b0;
    int          m_t = 0;
    int          m_plen = 0;
    logic        m_we = 1'b0;
    logic        m_a3 = 1'b0;
    logic [2:0]  m_da = '0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;
    logic        m_err = 1'b0;
    logic        m_rdy1 = 1'b1, m_rdy2 = 1'b1, m_irq1 = 1'b0, m_irq2 = 1'b0;
    logic [16:0] exp_q[$];

    initial forever begin
        @(posedge clk or negedge reset_);
        if (!reset_) begin
            m_active = 1'b0; m_t = 0; m_plen = 0; m_we = 1'b0; m_a3 = 1'b0;
            m_da = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
            m_rdy1 = 1'b1; m_rdy2 = 1'b1; m_irq1 = 1'b0; m_irq2 = 1'b0;
            exp_q.delete();
        end else begin
            logic rdy_now;
            int   p;
            rdy_now = m_rdy2;
            m_rdy2 = m_rdy1; m_rdy1 = iordy;
            m_irq2 = m_irq1; m_irq1 = intrq;
            if (!m_active) begin
                if (req) begin
                    m_active = 1'b1; m_t = 1; m_plen = 0; m_err = 1'b0;
                    m_we = we; m_a3 = addr[3]; m_da = addr[2:0]; m_wdata = wdata;
                end
            end else begin
                if (m_plen == 0 && m_t > T_SETUP) begin
                    p = m_t - T_SETUP;
                    if (p >= T_PULSE && rdy_now) begin
                        m_plen = p;
                        if (!m_we) m_rdata = dd_in;
                        exp_q.push_back({1'b0, m_rdata});
                    end else if (p - T_PULSE == TMO) begin
                        m_plen = p;
                        m_err = 1'b1;
                        if (!m_we) m_rdata = 16'hFFFF;
                        exp_q.push_back({1'b1, m_rdata});
                    end
                end
                m_t++;
                if (m_plen != 0 && m_t > T_SETUP + m_plen + T_HOLD + T_RECOV) m_active = 1'b0;
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (reset_) begin
            logic in_cs, in_st, e_ack;
            logic [16:0] e;
            int he;
            he    = T_SETUP + m_plen + T_HOLD;
            in_cs = m_active && (m_plen == 0 || m_t <= he);
            in_st = m_active && m_t > T_SETUP && (m_plen == 0 || m_t <= T_SETUP + m_plen);
            e_ack = m_active && m_plen != 0 && m_t == he + 1;
            chk("busy", busy, m_active);
            chk("ack", ack, e_ack);
            chk("cs1fx_", cs1fx_, !(in_cs && !m_a3));
            chk("cs3fx_", cs3fx_, !(in_cs && m_a3));
            chk("dior_", dior_, !(in_st && !m_we));
            chk("diow_", diow_, !(in_st && m_we));
            chk("dd_oe", dd_oe, in_cs && m_we);
            if (in_cs && m_we) chk("dd_out", dd_out, m_wdata);
            chk("da", da, m_da);
            chk("rdata", rdata, m_rdata);
            chk("irq", irq, m_irq2);
            if (ack) begin
                if (rand_phase) rand_acks++;
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_err", err, e[16]);
                    chk("ack_rdata", rdata, e[15:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge with the engine idle; returns just after
    // the accepting edge so the next falling edge is the first SETUP cycle.
    task automatic start_req(input logic w, input logic [3:0] a, input logic [15:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic measure(input int rise_at, output int s_lo, output int c_lo, output int ack_at,
                           output int idle_at, output int oe_n, output logic e_v, output logic [15:0] r_v);
        int n;
        n = 0; s_lo = 0; c_lo = 0; ack_at = -1; idle_at = -1; oe_n = 0; e_v = 1'bx; r_v = 'x;
        while (idle_at < 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (!dior_ || !diow_) s_lo++;
            if (!cs1fx_ || !cs3fx_) c_lo++;
            if (dd_oe) oe_n++;
            if (ack) begin ack_at = n; e_v = err; r_v = rdata; end
            if (!busy) idle_at = n;
            if (n == rise_at) iordy = 1'b1;
        end
    endtask

    initial begin
        int s_lo, c_lo, ack_at, idle_at, oe_n, n, acks, a1, a2, both, low_left;
        logic e_v, drop;
        logic [15:0] r_v;

        #2 reset_ = 1'b0;
        #1;
        chk("rst_busy", busy, 0);     chk("rst_ack", ack, 0);       chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);   chk("rst_irq", irq, 0);       chk("rst_da", da, 0);
        chk("rst_cs1", cs1fx_, 1);    chk("rst_cs3", cs3fx_, 1);    chk("rst_dior", dior_, 1);
        chk("rst_diow", diow_, 1);    chk("rst_dd_oe", dd_oe, 0);   chk("rst_dd_out", dd_out, 0);
        chk("rst_state", dbg_state, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_ = 1'b1;
        @(posedge clk); #1;

        start_req(1'b1, 4'h7, 16'h00A0);
        measure(0, s_lo, c_lo, ack_at, idle_at, oe_n, e_v, r_v);
        chk("wr_strobe_len", s_lo, 12);  chk("wr_cs_len", c_lo, 17);  chk("wr_oe_len", oe_n, 17);
        chk("wr_ack_at", ack_at, 18);    chk("wr_err", e_v, 0);       chk("wr_busy_drop", idle_at - ack_at, 8);
        chk("wr_da", da, 7);

        @(posedge clk); #1;
        dd_in = 16'h0050;
        start_req(1'b0, 4'hE, 16'h1111);
        measure(0, s_lo, c_lo, ack_at, idle_at, oe_n, e_v, r_v);
        chk("rd_strobe_len", s_lo, 12);  chk("rd_oe_len", oe_n, 0);   chk("rd_ack_at", ack_at, 18);
        chk("rd_rdata", r_v, 16'h0050);  chk("rd_err", e_v, 0);       chk("rd_da", da, 6);

        @(posedge clk); #1;
        iordy = 1'b0; dd_in = 16'h1234;
        start_req(1'b0, 4'h1, 16'h0);
        measure(T_SETUP + 20, s_lo, c_lo, ack_at, idle_at, oe_n, e_v, r_v);
        chk("wait_strobe_len", s_lo, 22); chk("wait_ack_at", ack_at, 28);
        chk("wait_rdata", r_v, 16'h1234); chk("wait_err", e_v, 0);

        @(posedge clk); #1;
        iordy = 1'b0; dd_in = 16'h5A5A;
        start_req(1'b0, 4'h2, 16'h0);
        measure(0, s_lo, c_lo, ack_at, idle_at, oe_n, e_v, r_v);
        chk("tmo_strobe_len", s_lo, 28);  chk("tmo_ack_at", ack_at, 34);
        chk("tmo_err", e_v, 1);           chk("tmo_rdata", r_v, 16'hFFFF);
        iordy = 1'b1;
        @(posedge clk); #1;
        start_req(1'b1, 4'h9, 16'hC0DE);
        measure(0, s_lo, c_lo, ack_at, idle_at, oe_n, e_v, r_v);
        chk("after_tmo_strobe_len", s_lo, 12); chk("after_tmo_err", e_v, 0); chk("after_tmo_ack_at", ack_at, 18);

        @(posedge clk); #1;
        dd_in = 16'h7777;
        start_req(1'b1, 4'h3, 16'hBEEF);
        n = 0; acks = 0; a1 = -1; a2 = -1; both = 0; drop = 1'b0; r_v = '0;
        while (n < 80) begin
            @(negedge clk);
            n++;
            if (drop) begin req = 1'b0; drop = 1'b0; end
            if (!dior_ && !diow_) both++;
            if (ack) begin
                acks++;
                if (a1 < 0) begin a1 = n; req = 1'b1; we = 1'b0; addr = 4'hC; end
                else begin a2 = n; r_v = rdata; end
            end else if (req && a1 >= 0 && !busy) begin
                drop = 1'b1;
            end
        end
        req = 1'b0;
        chk("b2b_acks", acks, 2);        chk("b2b_gap", a2 - a1, 26);
        chk("b2b_overlap", both, 0);     chk("b2b_rdata", r_v, 16'h7777);

        @(negedge clk) intrq = 1'b1;
        @(negedge clk) chk("irq_rise_1clk", irq, 0);
        @(negedge clk) chk("irq_rise_2clk", irq, 1);
        intrq = 1'b0;
        @(negedge clk) chk("irq_fall_1clk", irq, 1);
        @(negedge clk) chk("irq_fall_2clk", irq, 0);

        @(posedge clk); #1;
        start_req(1'b0, 4'h5, 16'h0);
        n = 0;
        while (dior_ && n < 30) begin @(negedge clk); n++; end
        chk("rst_mid_reached_pulse", dior_, 0);
        #2 reset_ = 1'b0;
        #1;
        chk("rst_mid_dior", dior_, 1);   chk("rst_mid_diow", diow_, 1);  chk("rst_mid_cs1", cs1fx_, 1);
        chk("rst_mid_cs3", cs3fx_, 1);   chk("rst_mid_busy", busy, 0);   chk("rst_mid_ack", ack, 0);
        @(negedge clk) reset_ = 1'b1;
        acks = 0;
        repeat (40) begin @(negedge clk); if (ack) acks++; end
        chk("rst_mid_no_ack", acks, 0);

        @(posedge clk); #1;
        rand_phase = 1'b1;
        low_left = 0;
        repeat (3000) begin
            @(posedge clk); #1;
            req   = ($urandom_range(0, 3) == 0);
            we    = 1'($urandom_range(0, 1));
            addr  = 4'($urandom_range(0, 15));
            wdata = 16'($urandom);
            dd_in = 16'($urandom);
            if ($urandom_range(0, 7) == 0) intrq = ~intrq;
            if (low_left > 0) begin
                iordy = 1'b0;
                low_left--;
            end else begin
                iordy = 1'b1;
                if ($urandom_range(0, 29) == 0) low_left = $urandom_range(1, 45);
            end
        end
        req = 1'b0; iordy = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        rand_phase = 1'b0;
        chk("rand_enough_acks", (rand_acks >= 20), 1);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("rand_idle_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
